// File: rtl/reg_bank_pkg.sv
// Shared types and sizing helpers for the parametrised register bank.
package reg_bank_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_DEPTH = 4;

    // Address width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_bank_storage.sv
// DEPTH x WIDTH storage array: one synchronous write port, two combinational read muxes.
module reg_bank_storage
    import reg_bank_pkg::*;
#(
    parameter  int unsigned WIDTH  = DEF_WIDTH,
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [WIDTH-1:0]  o_rd_data1_c,
    output logic [WIDTH-1:0]  o_rd_data2_c
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data1_c = r_mem[i_rd_addr1];
    assign o_rd_data2_c = r_mem[i_rd_addr2];

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank: addressed write, dual registered read, sequenced clear with busy.
module reg_bank_param
    import reg_bank_pkg::*;
#(
    parameter  int unsigned WIDTH  = DEF_WIDTH,
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_reg,
    input  logic              w_r_reg,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wd_reg,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              clr_req,
    output logic [WIDTH-1:0]  rd_reg1,
    output logic [WIDTH-1:0]  rd_reg2,
    output logic              rd_valid,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_busy;
    logic              r_rd_valid;
    logic [WIDTH-1:0]  r_rd1;
    logic [WIDTH-1:0]  r_rd2;

    logic              w_clr_we;
    logic              w_acc;
    logic              w_wr;
    logic              w_rd;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [WIDTH-1:0]  w_mem_data;
    logic [WIDTH-1:0]  w_rd_data1;
    logic [WIDTH-1:0]  w_rd_data2;

    // Accesses only count in IDLE, and a same-cycle clear request drops them.
    assign w_acc = (r_state == ST_IDLE) && enable_reg && !clr_req;
    assign w_wr  = w_acc && w_r_reg;
    assign w_rd  = w_acc && !w_r_reg;

    // Clear sequencer owns the write port while it runs.
    assign w_mem_we   = w_wr || w_clr_we;
    assign w_mem_addr = w_clr_we ? r_clr_idx : wr_addr;
    assign w_mem_data = w_clr_we ? '0 : wd_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_we    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_idx == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx  <= '0;
            r_busy     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd1      <= '0;
            r_rd2      <= '0;
        end else begin
            r_clr_idx  <= w_clr_we ? (r_clr_idx + ADDR_W'(1)) : '0;
            r_busy     <= (w_state_nxt == ST_CLEAR);
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd1 <= w_rd_data1;
                r_rd2 <= w_rd_data2;
            end
        end
    end

    reg_bank_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk          (clk),
        .rst          (rst),
        .i_we         (w_mem_we),
        .i_wr_addr    (w_mem_addr),
        .i_wr_data    (w_mem_data),
        .i_rd_addr1   (rd_addr1),
        .i_rd_addr2   (rd_addr2),
        .o_rd_data1_c (w_rd_data1),
        .o_rd_data2_c (w_rd_data2)
    );

    assign rd_reg1  = r_rd1;
    assign rd_reg2  = r_rd2;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;

endmodule
